param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MAX, default 2**WIDTH-1, giving the modulo upper bound (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter SAT_MODE, default 0: 0 means wrap at bounds, 1 means saturate at bounds.
REQ-004 The block SHALL have parameter RST_VAL, default 0, giving the reset value of dout (legal range 0..MAX).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: count enable.
REQ-008 The block SHALL have port up, input, 1 bit: direction, 1 counts up and 0 counts down; sampled only when en=1.
REQ-009 The block SHALL have port load, input, 1 bit: parallel load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: the value to load.
REQ-011 The block SHALL have port clr_flags, input, 1 bit: clears the sticky flags.
REQ-012 The block SHALL have port dout, output, WIDTH bits: the registered count.
REQ-013 The block SHALL have port tc, output, 1 bit: a registered one-cycle terminal-count pulse.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky overflow flag (up-count attempted at MAX).
REQ-015 The block SHALL have port unf, output, 1 bit: sticky underflow flag (down-count attempted at 0).

Function
REQ-016 Per rising edge, priority SHALL be: rst > load > en > hold.
REQ-017 load=1 SHALL set dout to min(load_val, MAX) on the next edge, regardless of en and up; tc SHALL be 0 that cycle and flags SHALL be unchanged except by clr_flags.
REQ-018 en=1 with up=1 and dout<MAX SHALL give dout+1; en=1 with up=0 and dout>0 SHALL give dout-1; latency SHALL be one clock.
REQ-019 Up at dout==MAX SHALL give dout=0 when SAT_MODE=0 and dout=MAX (held) when SAT_MODE=1; both cases SHALL set ovf and pulse tc.
REQ-020 Down at dout==0 SHALL give dout=MAX when SAT_MODE=0 and dout=0 (held) when SAT_MODE=1; both cases SHALL set unf and pulse tc.
REQ-021 tc SHALL be high for exactly the one cycle following the boundary edge, coincident with the new dout; it SHALL be 0 otherwise, including every held cycle in saturation after the first.
REQ-022 Sustained en=1 in saturation SHALL set ovf or unf again on each edge but SHALL not retrigger tc until the count has left the bound.
REQ-023 en=0 with load=0 SHALL hold dout and drive tc=0.
REQ-024 clr_flags=1 SHALL clear ovf and unf on the next edge; a boundary event on the same edge SHALL win, leaving that flag set.
REQ-025 A direction change on any edge SHALL take effect immediately with no dead cycle.
REQ-026 All arithmetic SHALL be modulo MAX+1 only; dout SHALL never exceed MAX.

Reset
REQ-027 rst=1 at an edge SHALL set dout=RST_VAL, tc=0, ovf=0, unf=0, overriding load, en and clr_flags.
REQ-028 Reset asserted mid-count SHALL take effect on the next edge; dout SHALL stay RST_VAL for every cycle rst is held.
REQ-029 Counting SHALL resume on the first edge with rst=0 and en=1.

Configuration
REQ-030 Macro PARAM_UPDOWN_COUNTER_ASSERT_EN, when defined, SHALL compile in embedded concurrent assertions: dout==RST_VAL during rst, dout<=MAX always, no X on outputs after reset, tc one cycle wide, and correct +1/-1/wrap/saturate steps (each disabled during rst and load).
REQ-031 Without PARAM_UPDOWN_COUNTER_ASSERT_EN, no checker logic SHALL be present, and functional behaviour SHALL be identical.

Verification (WIDTH=4, MAX=9, SAT_MODE=0, RST_VAL=0 unless noted)
REQ-032 Reset: rst=1 for 3 cycles, then en=1, up=1 -> dout=0 throughout reset, then 1, 2, 3...; no X after the first edge.
REQ-033 Up wrap: counting from 7, 3 up-edges -> dout 8, 9, 0; tc=1 only with dout=0; ovf=1 and stays set.
REQ-034 Down wrap with clr: from 1, 2 down-edges -> dout 0, 9; unf=1 and tc pulses with dout=9; then clr_flags=1 -> unf=0 next cycle.
REQ-035 SAT_MODE=1: up held at 9 for 4 edges -> dout=9 throughout; tc high 1 cycle only; ovf=1; clr_flags on same edge as a saturating up -> ovf stays 1.
REQ-036 Load: load_val=12 with en=1 -> dout=9 next edge, tc=0; load_val=4 with rst=1 on the same edge -> dout=0.
REQ-037 Mid-count reset: counting up at 5, rst for 1 cycle -> dout=0; then 1 after the first en edge; flags cleared.

Source files
------------

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Modulo-(MAX+1) up/down counter with parallel load, wrap or saturate
// behaviour at the bounds, a registered terminal-count pulse and sticky
// overflow / underflow flags.
//
// Parameters
//   WIDTH    counter width in bits (2..32)
//   MAX      upper bound of the count (1..2**WIDTH-1)
//   SAT_MODE 0 = wrap at the bounds, 1 = saturate at the bounds
//   RST_VAL  value of dout after reset (0..MAX)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   en         count enable
//   up         direction when en=1 (1 = up, 0 = down)
//   load       parallel load strobe (load_val is clamped to MAX)
//   load_val   value to load
//   clr_flags  clears ovf / unf (a boundary event on the same edge wins)
//   dout       registered count
//   tc         one-cycle terminal-count pulse, coincident with the new dout
//   ovf        sticky overflow (up-count attempted at MAX)
//   unf        sticky underflow (down-count attempted at 0)
//
// Compile-time option
//   PARAM_UPDOWN_COUNTER_ASSERT_EN  when defined, embedded concurrent
//                                   assertions are compiled in.
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter bit               SAT_MODE = 1'b0,
  parameter longint unsigned  RST_VAL  = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  // Set while the count sits at a bound because the previous boundary event
  // saturated; suppresses tc on the repeated boundary attempts that follow.
  logic             held;

  logic             at_max;
  logic             at_zero;
  logic             ovf_evt;
  logic             unf_evt;
  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] dout_nxt;
  logic             tc_nxt;
  logic             held_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    dout_nxt = dout;
    tc_nxt   = 1'b0;
    held_nxt = held;

    at_max   = (dout == MAX_V);
    at_zero  = (dout == '0);
    ovf_evt  = en && !load && up  && at_max;
    unf_evt  = en && !load && !up && at_zero;
    load_sat = (load_val > MAX_V) ? MAX_V : load_val;

    if (load) begin
      dout_nxt = load_sat;
      held_nxt = 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_max) dout_nxt = SAT_MODE ? MAX_V : '0;
        else        dout_nxt = dout + WIDTH'(1);
      end else begin
        if (at_zero) dout_nxt = SAT_MODE ? '0 : MAX_V;
        else         dout_nxt = dout - WIDTH'(1);
      end

      if (ovf_evt || unf_evt) begin
        // In wrap mode held never sets, so every boundary crossing pulses tc.
        tc_nxt   = !held;
        held_nxt = SAT_MODE;
      end else begin
        held_nxt = 1'b0;
      end
    end

    // Boundary event beats a simultaneous clear.
    ovf_nxt = ovf_evt || (ovf && !clr_flags);
    unf_nxt = unf_evt || (unf && !clr_flags);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      dout <= RST_V;
      tc   <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
      held <= 1'b0;
    end else begin
      dout <= dout_nxt;
      tc   <= tc_nxt;
      ovf  <= ovf_nxt;
      unf  <= unf_nxt;
      held <= held_nxt;
    end
  end

`ifdef PARAM_UPDOWN_COUNTER_ASSERT_EN
  // Tracks whether a reset has been seen so X checks start only afterwards.
  logic seen_rst;
  always_ff @(posedge clk) begin
    if (rst) seen_rst <= 1'b1;
  end

  a_rst_val: assert property (@(posedge clk) rst |=> (dout == RST_V));

  a_le_max: assert property (@(posedge clk)
    (seen_rst === 1'b1) |-> (dout <= MAX_V));

  a_no_x: assert property (@(posedge clk)
    (seen_rst === 1'b1) |-> !$isunknown({dout, tc, ovf, unf}));

  // Back-to-back pulses are legal only when a new boundary event occurs,
  // e.g. MAX=1 with the direction toggling every edge.
  a_tc_width: assert property (@(posedge clk) disable iff (rst)
    (tc && !(ovf_evt || unf_evt)) |=> !tc);

  a_inc: assert property (@(posedge clk) disable iff (rst)
    (!rst && !load && en && up && !at_max) |=> (dout == $past(dout) + WIDTH'(1)));

  a_dec: assert property (@(posedge clk) disable iff (rst)
    (!rst && !load && en && !up && !at_zero) |=> (dout == $past(dout) - WIDTH'(1)));

  a_top: assert property (@(posedge clk) disable iff (rst)
    (!rst && ovf_evt) |=> (dout == (SAT_MODE ? MAX_V : '0)) && ovf);

  a_bottom: assert property (@(posedge clk) disable iff (rst)
    (!rst && unf_evt) |=> (dout == (SAT_MODE ? '0 : MAX_V)) && unf);
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_param_updown_counter
//
// Drives a wrap-mode counter (WIDTH=4, MAX=9, RST_VAL=0) and a saturating
// counter (WIDTH=4, MAX=9, RST_VAL=3) from the same stimulus and compares both
// against an arithmetic reference model after every edge. Directed sequences
// cover reset, wrap, saturation, load clamping and flag clearing; a random
// phase follows.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

  localparam int MAXV  = 9;
  localparam int RST_S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       clr_flags = 1'b0;

  logic [3:0] dout_w, dout_s;
  logic       tc_w, ovf_w, unf_w;
  logic       tc_s, ovf_s, unf_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX(MAXV), .SAT_MODE(1'b0), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .dout(dout_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w)
  );

  param_updown_counter #(.WIDTH(4), .MAX(MAXV), .SAT_MODE(1'b1), .RST_VAL(RST_S)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .dout(dout_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s)
  );

  // Reference model: the count as a plain integer, stepped by +/-1 and folded
  // back into 0..MAX by modulo arithmetic or by clamping.
  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    bit unf;
    bit stuck;  // parked at a bound after a saturating attempt
  } mdl_t;

  mdl_t mw, ms;

  function automatic mdl_t mstep(mdl_t s, bit sat, int rv, bit r, bit ld,
                                 int lv, bit e, bit u, bit c);
    mdl_t n;
    int   t;
    n    = s;
    n.tc = 1'b0;
    if (r) begin
      n.cnt = rv; n.ovf = 1'b0; n.unf = 1'b0; n.stuck = 1'b0;
      return n;
    end
    if (c) begin
      n.ovf = 1'b0; n.unf = 1'b0;
    end
    if (ld) begin
      n.cnt   = (lv > MAXV) ? MAXV : lv;
      n.stuck = 1'b0;
    end else if (e) begin
      t = s.cnt + (u ? 1 : -1);
      if (t > MAXV || t < 0) begin
        if (u) n.ovf = 1'b1;
        else   n.unf = 1'b1;
        n.cnt   = sat ? s.cnt : (t + MAXV + 1) % (MAXV + 1);
        n.tc    = !s.stuck;
        n.stuck = sat;
      end else begin
        n.cnt   = t;
        n.stuck = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one set of inputs across one rising edge, advance the models and
  // compare every output of both counters just after the edge.
  task automatic tick(input bit r, input bit ld, input int lv, input bit e,
                      input bit u, input bit c);
    rst = r; load = ld; load_val = 4'(lv); en = e; up = u; clr_flags = c;
    @(posedge clk);
    mw = mstep(mw, 1'b0, 0,     r, ld, lv, e, u, c);
    ms = mstep(ms, 1'b1, RST_S, r, ld, lv, e, u, c);
    #1;
    check("w_dout", 32'(dout_w), 32'(mw.cnt));
    check("w_tc",   32'(tc_w),   32'(mw.tc));
    check("w_ovf",  32'(ovf_w),  32'(mw.ovf));
    check("w_unf",  32'(unf_w),  32'(mw.unf));
    check("s_dout", 32'(dout_s), 32'(ms.cnt));
    check("s_tc",   32'(tc_s),   32'(ms.tc));
    check("s_ovf",  32'(ovf_s),  32'(ms.ovf));
    check("s_unf",  32'(unf_s),  32'(ms.unf));
  endtask

  initial begin
    mw = '{cnt: 0, tc: 1'b0, ovf: 1'b0, unf: 1'b0, stuck: 1'b0};
    ms = mw;

    // Reset held three cycles, then count up from 0.
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 1, 1, 0);
      check("rst_dout", 32'(dout_w), 32'd0);
      check("rst_noX", 32'($isunknown({dout_w, tc_w, ovf_w, unf_w})), 32'd0);
    end
    check("rst_sat_val", 32'(dout_s), 32'(RST_S));
    for (int i = 1; i <= 3; i++) begin
      tick(0, 0, 0, 1, 1, 0);
      check("cnt_up", 32'(dout_w), 32'(i));
    end

    // Up wrap from 7: 8, 9, 0 with tc only alongside 0.
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 7, 0, 0, 0);
    tick(0, 0, 0, 1, 1, 0);
    check("wrap_8", 32'(dout_w), 32'd8);
    check("wrap_8_tc", 32'(tc_w), 32'd0);
    tick(0, 0, 0, 1, 1, 0);
    check("wrap_9", 32'(dout_w), 32'd9);
    tick(0, 0, 0, 1, 1, 0);
    check("wrap_0", 32'(dout_w), 32'd0);
    check("wrap_0_tc", 32'(tc_w), 32'd1);
    check("wrap_ovf", 32'(ovf_w), 32'd1);
    tick(0, 0, 0, 0, 1, 0);
    check("wrap_ovf_sticky", 32'(ovf_w), 32'd1);
    check("hold_tc", 32'(tc_w), 32'd0);

    // Down wrap from 1: 0, 9 with unf, then clear.
    tick(0, 1, 1, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 0);
    check("dwrap_0", 32'(dout_w), 32'd0);
    tick(0, 0, 0, 1, 0, 0);
    check("dwrap_9", 32'(dout_w), 32'd9);
    check("dwrap_tc", 32'(tc_w), 32'd1);
    check("dwrap_unf", 32'(unf_w), 32'd1);
    tick(0, 0, 0, 0, 0, 1);
    check("dwrap_clr", 32'(unf_w), 32'd0);

    // Saturation: held at 9 for 4 up edges, one tc pulse, ovf survives clear.
    tick(0, 1, 9, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 1, 1, 0);
      check("sat_dout", 32'(dout_s), 32'd9);
      check("sat_tc", 32'(tc_s), (i == 0) ? 32'd1 : 32'd0);
    end
    tick(0, 0, 0, 1, 1, 1);
    check("sat_clr_ovf", 32'(ovf_s), 32'd1);
    // Leaving the bound re-arms tc.
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    check("sat_rearm_tc", 32'(tc_s), 32'd1);

    // Load clamps to MAX and suppresses tc; reset beats load.
    tick(0, 1, 12, 1, 1, 0);
    check("load_clamp", 32'(dout_w), 32'd9);
    check("load_tc", 32'(tc_w), 32'd0);
    tick(1, 1, 4, 1, 1, 0);
    check("rst_over_load", 32'(dout_w), 32'd0);

    // Mid-count reset at 5.
    tick(0, 1, 5, 0, 0, 0);
    tick(1, 0, 0, 1, 1, 0);
    check("mid_rst", 32'(dout_w), 32'd0);
    check("mid_rst_flags", 32'({ovf_w, unf_w}), 32'd0);
    tick(0, 0, 0, 1, 1, 0);
    check("mid_resume", 32'(dout_w), 32'd1);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(63) == 0, $urandom_range(7) == 0, int'($urandom_range(15)),
           $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
